// File: rtl/conv_window_seq_pkg.sv
// rtl/conv_window_seq_pkg.sv - shared FSM encoding, dimension and index helpers
package conv_window_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int res_dim(input int img_n, input int k_n, input int pad, input int step);
    return (img_n - k_n + 2 * pad) / step + 1;
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int img_index(input int ch, input int r, input int q,
                                   input int rows, input int cols);
    return (ch * rows + r) * cols + q;
  endfunction

  function automatic int wei_index(input int ch, input int kr, input int kc,
                                   input int k_rows, input int k_cols);
    return (ch * k_rows + kr) * k_cols + kc;
  endfunction

endpackage

// File: rtl/conv_window_cnt.sv
// rtl/conv_window_cnt.sv - nested anchor/channel/kernel counter chain
// Order outermost first: anchor row, anchor column, channel, kernel row, kernel column.
module conv_window_cnt
  import conv_window_seq_pkg::*;
#(
  parameter int res_h = 3,
  parameter int res_w = 3,
  parameter int chans = 1,
  parameter int k_h   = 2,
  parameter int k_w   = 2,
  localparam int AL_W = cnt_width(res_h - 1),
  localparam int AC_W = cnt_width(res_w - 1),
  localparam int CH_W = cnt_width(chans - 1),
  localparam int KR_W = cnt_width(k_h - 1),
  localparam int KC_W = cnt_width(k_w - 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            advance_i,
  output logic [AL_W-1:0] al_o,
  output logic [AC_W-1:0] ac_o,
  output logic [CH_W-1:0] ch_o,
  output logic [KR_W-1:0] kr_o,
  output logic [KC_W-1:0] kc_o,
  output logic            win_last_o,
  output logic            frame_last_o
);

  localparam logic [AL_W-1:0] AL_MAX = AL_W'(res_h - 1);
  localparam logic [AC_W-1:0] AC_MAX = AC_W'(res_w - 1);
  localparam logic [CH_W-1:0] CH_MAX = CH_W'(chans - 1);
  localparam logic [KR_W-1:0] KR_MAX = KR_W'(k_h - 1);
  localparam logic [KC_W-1:0] KC_MAX = KC_W'(k_w - 1);

  logic [AL_W-1:0] al_q, al_d;
  logic [AC_W-1:0] ac_q, ac_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [KR_W-1:0] kr_q, kr_d;
  logic [KC_W-1:0] kc_q, kc_d;
  logic last_al, last_ac, last_ch, last_kr, last_kc;

  assign last_al = (al_q == AL_MAX);
  assign last_ac = (ac_q == AC_MAX);
  assign last_ch = (ch_q == CH_MAX);
  assign last_kr = (kr_q == KR_MAX);
  assign last_kc = (kc_q == KC_MAX);

  assign win_last_o   = last_ch && last_kr && last_kc;
  assign frame_last_o = win_last_o && last_ac && last_al;

  // Each level wraps to zero, so the chain is back at window (0,0) after the final element.
  always_comb begin
    al_d = al_q;
    ac_d = ac_q;
    ch_d = ch_q;
    kr_d = kr_q;
    kc_d = kc_q;
    if (advance_i) begin
      kc_d = last_kc ? '0 : kc_q + KC_W'(1);
      if (last_kc) begin
        kr_d = last_kr ? '0 : kr_q + KR_W'(1);
        if (last_kr) begin
          ch_d = last_ch ? '0 : ch_q + CH_W'(1);
          if (last_ch) begin
            ac_d = last_ac ? '0 : ac_q + AC_W'(1);
            if (last_ac) begin
              al_d = last_al ? '0 : al_q + AL_W'(1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      al_q <= '0;
      ac_q <= '0;
      ch_q <= '0;
      kr_q <= '0;
      kc_q <= '0;
    end else begin
      al_q <= al_d;
      ac_q <= ac_d;
      ch_q <= ch_d;
      kr_q <= kr_d;
      kc_q <= kc_d;
    end
  end

  assign al_o = al_q;
  assign ac_o = ac_q;
  assign ch_o = ch_q;
  assign kr_o = kr_q;
  assign kc_o = kc_q;

endmodule

// File: rtl/conv_window_seq.sv
// rtl/conv_window_seq.sv - multi-channel conv window sequencer streaming (image, weight) pairs
// Note: rst_n is an active-high synchronous reset despite its name.
module conv_window_seq
  import conv_window_seq_pkg::*;
#(
  parameter int weight_width  = 2,
  parameter int weight_height = 2,
  parameter int img_width     = 4,
  parameter int img_height    = 4,
  parameter int channels      = 1,
  parameter int padding       = 0,
  parameter int stride        = 1,
  parameter int bitwidth      = 16
) (
  input  logic                                                 clk_en,
  input  logic                                                 rst_n,
  input  logic                                                 conv_on,
  input  logic [channels*img_height*img_width*bitwidth-1:0]    img,
  input  logic [channels*weight_height*weight_width*bitwidth-1:0] weight,
  input  logic                                                 out_ready,
  output logic [bitwidth-1:0]                                  img_cal,
  output logic [bitwidth-1:0]                                  wei_cal,
  output logic                                                 cal_valid,
  output logic                                                 win_last,
  output logic                                                 frame_done,
  output logic [31:0]                                          anchor_l,
  output logic [31:0]                                          anchor_c,
  output logic                                                 busy
);

  localparam int result_width  = res_dim(img_width, weight_width, padding, stride);
  localparam int result_height = res_dim(img_height, weight_height, padding, stride);
  localparam int IMG_N  = channels * img_height * img_width;
  localparam int WEI_N  = channels * weight_height * weight_width;
  localparam int IMG_AW = cnt_width(IMG_N - 1);
  localparam int WEI_AW = cnt_width(WEI_N - 1);
  localparam int AL_W   = cnt_width(result_height - 1);
  localparam int AC_W   = cnt_width(result_width - 1);
  localparam int CH_W   = cnt_width(channels - 1);
  localparam int KR_W   = cnt_width(weight_height - 1);
  localparam int KC_W   = cnt_width(weight_width - 1);

  state_e state_q, state_d;
  logic [IMG_N*bitwidth-1:0] img_q;
  logic [WEI_N*bitwidth-1:0] weight_q;
  logic run, start, advance, win_last_c, frame_last_c;
  logic [AL_W-1:0] al;
  logic [AC_W-1:0] ac;
  logic [CH_W-1:0] ch;
  logic [KR_W-1:0] kr;
  logic [KC_W-1:0] kc;

  assign run     = (state_q == ST_RUN);
  assign start   = (state_q == ST_IDLE) && conv_on;
  assign advance = run && out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (conv_on) state_d = ST_RUN;
      ST_RUN:  if (advance && frame_last_c) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_en) begin
    if (rst_n) begin
      state_q  <= ST_IDLE;
      img_q    <= '0;
      weight_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        img_q    <= img;
        weight_q <= weight;
      end
    end
  end

  conv_window_cnt #(
    .res_h(result_height),
    .res_w(result_width),
    .chans(channels),
    .k_h  (weight_height),
    .k_w  (weight_width)
  ) u_cnt (
    .clk_i       (clk_en),
    .rst_i       (rst_n),
    .clear_i     (start),
    .advance_i   (advance),
    .al_o        (al),
    .ac_o        (ac),
    .ch_o        (ch),
    .kr_o        (kr),
    .kc_o        (kc),
    .win_last_o  (win_last_c),
    .frame_last_o(frame_last_c)
  );

  // Power-of-two element tables so a truncated index never leaves the array.
  logic [bitwidth-1:0] img_arr [2**IMG_AW];
  logic [bitwidth-1:0] wei_arr [2**WEI_AW];

  for (genvar i = 0; i < 2**IMG_AW; i++) begin : g_img
    if (i < IMG_N) begin : g_v
      assign img_arr[i] = img_q[i*bitwidth +: bitwidth];
    end else begin : g_z
      assign img_arr[i] = '0;
    end
  end

  for (genvar i = 0; i < 2**WEI_AW; i++) begin : g_wei
    if (i < WEI_N) begin : g_v
      assign wei_arr[i] = weight_q[i*bitwidth +: bitwidth];
    end else begin : g_z
      assign wei_arr[i] = '0;
    end
  end

  int src_r, src_c;
  logic in_img;
  logic [IMG_AW-1:0] img_idx;
  logic [WEI_AW-1:0] wei_idx;

  // Signed source coordinates: negative or past-the-edge positions are padding.
  always_comb begin
    src_r   = int'(al) * stride + int'(kr) - padding;
    src_c   = int'(ac) * stride + int'(kc) - padding;
    in_img  = (src_r >= 0) && (src_r < img_height) && (src_c >= 0) && (src_c < img_width);
    img_idx = IMG_AW'(img_index(int'(ch), src_r, src_c, img_height, img_width));
    wei_idx = WEI_AW'(wei_index(int'(ch), int'(kr), int'(kc), weight_height, weight_width));
  end

  assign img_cal    = (run && in_img) ? img_arr[img_idx] : '0;
  assign wei_cal    = run ? wei_arr[wei_idx] : '0;
  assign cal_valid  = run;
  assign win_last   = run && win_last_c;
  assign frame_done = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign anchor_l   = 32'(al);
  assign anchor_c   = 32'(ac);

endmodule

// File: tb/tb_conv_window_seq.sv
// tb/tb_conv_window_seq.sv - self-checking bench for conv_window_seq across four configurations
module tb_conv_window_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         out_ready;
  logic         conv_on [4];
  logic [511:0] img_bus;
  logic [143:0] w_bus;
  logic [15:0]  o_img [4];
  logic [15:0]  o_wei [4];
  logic         o_valid [4];
  logic         o_last [4];
  logic         o_done [4];
  logic         o_busy [4];
  logic [31:0]  o_al [4];
  logic [31:0]  o_ac [4];

  int tests = 0;
  int fails = 0;

  int img_m [32];
  int wei_m [9];
  int exp_img[$], exp_wei[$], exp_last[$], exp_al[$], exp_ac[$];
  int got_img[$], got_wei[$], got_last[$], got_al[$], got_ac[$];

  conv_window_seq u0 (
    .clk_en(clk), .rst_n(rst), .conv_on(conv_on[0]), .img(img_bus[255:0]), .weight(w_bus[63:0]),
    .out_ready(out_ready), .img_cal(o_img[0]), .wei_cal(o_wei[0]), .cal_valid(o_valid[0]),
    .win_last(o_last[0]), .frame_done(o_done[0]), .anchor_l(o_al[0]), .anchor_c(o_ac[0]), .busy(o_busy[0])
  );

  conv_window_seq #(.weight_width(3), .weight_height(3), .padding(1)) u1 (
    .clk_en(clk), .rst_n(rst), .conv_on(conv_on[1]), .img(img_bus[255:0]), .weight(w_bus[143:0]),
    .out_ready(out_ready), .img_cal(o_img[1]), .wei_cal(o_wei[1]), .cal_valid(o_valid[1]),
    .win_last(o_last[1]), .frame_done(o_done[1]), .anchor_l(o_al[1]), .anchor_c(o_ac[1]), .busy(o_busy[1])
  );

  conv_window_seq #(.stride(2)) u2 (
    .clk_en(clk), .rst_n(rst), .conv_on(conv_on[2]), .img(img_bus[255:0]), .weight(w_bus[63:0]),
    .out_ready(out_ready), .img_cal(o_img[2]), .wei_cal(o_wei[2]), .cal_valid(o_valid[2]),
    .win_last(o_last[2]), .frame_done(o_done[2]), .anchor_l(o_al[2]), .anchor_c(o_ac[2]), .busy(o_busy[2])
  );

  conv_window_seq #(.channels(2)) u3 (
    .clk_en(clk), .rst_n(rst), .conv_on(conv_on[3]), .img(img_bus), .weight(w_bus[127:0]),
    .out_ready(out_ready), .img_cal(o_img[3]), .wei_cal(o_wei[3]), .cal_valid(o_valid[3]),
    .win_last(o_last[3]), .frame_done(o_done[3]), .anchor_l(o_al[3]), .anchor_c(o_ac[3]), .busy(o_busy[3])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_buses();
    for (int i = 0; i < 32; i++) img_bus[i*16 +: 16] = 16'(img_m[i]);
    for (int i = 0; i < 9; i++)  w_bus[i*16 +: 16]   = 16'(wei_m[i]);
  endtask

  // Expected stream for a 4x4 image, straight from the window/padding rules.
  task automatic build(input int kh, input int kw, input int nch, input int pad, input int st);
    int rh, rw, r, q;
    rh = (4 - kh + 2 * pad) / st + 1;
    rw = (4 - kw + 2 * pad) / st + 1;
    exp_img.delete(); exp_wei.delete(); exp_last.delete(); exp_al.delete(); exp_ac.delete();
    for (int a_l = 0; a_l < rh; a_l++)
      for (int a_c = 0; a_c < rw; a_c++)
        for (int c = 0; c < nch; c++)
          for (int k_r = 0; k_r < kh; k_r++)
            for (int k_c = 0; k_c < kw; k_c++) begin
              r = a_l * st + k_r - pad;
              q = a_c * st + k_c - pad;
              exp_img.push_back((r < 0 || r >= 4 || q < 0 || q >= 4) ? 0 : img_m[(c * 4 + r) * 4 + q]);
              exp_wei.push_back(wei_m[(c * kh + k_r) * kw + k_c]);
              exp_last.push_back((c == nch - 1 && k_r == kh - 1 && k_c == kw - 1) ? 1 : 0);
              exp_al.push_back(a_l);
              exp_ac.push_back(a_c);
            end
  endtask

  // mode 0: ready always high; 1: random ready; 2: three-cycle stall on element 5.
  task automatic run_frame(input int u, input int mode, input int abort_at);
    int n, cyc, stall, total;
    n = 0; cyc = 0; stall = 0; total = exp_img.size();
    got_img.delete(); got_wei.delete(); got_last.delete(); got_al.delete(); got_ac.delete();
    @(negedge clk);
    conv_on[u] = 1'b1;
    while (1) begin
      @(negedge clk);
      conv_on[u] = 1'b0;
      cyc++;
      if (n == abort_at) return;
      if (n == total) begin
        chk($sformatf("u%0d frame_done pulse", u), 32'(o_done[u]), 1);
        chk($sformatf("u%0d valid in done", u), 32'(o_valid[u]), 0);
        @(negedge clk);
        chk($sformatf("u%0d frame_done width", u), 32'(o_done[u]), 0);
        chk($sformatf("u%0d busy after done", u), 32'(o_busy[u]), 0);
        return;
      end
      if (cyc > 4000) begin
        chk($sformatf("u%0d timeout accepted", u), n, total);
        return;
      end
      chk($sformatf("u%0d e%0d valid", u, n), 32'(o_valid[u]), 1);
      chk($sformatf("u%0d e%0d busy", u, n), 32'(o_busy[u]), 1);
      chk($sformatf("u%0d e%0d early done", u, n), 32'(o_done[u]), 0);
      case (mode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: if (n == 4 && stall < 3) begin out_ready = 1'b0; stall++; end else out_ready = 1'b1;
        default: out_ready = 1'b1;
      endcase
      if (mode == 2 && n == 4 && stall > 0) begin
        chk($sformatf("stall%0d img", stall), 32'(o_img[u]), 2);
        chk($sformatf("stall%0d anchor_l", stall), o_al[u], 0);
        chk($sformatf("stall%0d anchor_c", stall), o_ac[u], 1);
      end
      if (out_ready) begin
        chk($sformatf("u%0d e%0d img", u, n), 32'(o_img[u]), exp_img[n]);
        chk($sformatf("u%0d e%0d wei", u, n), 32'(o_wei[u]), exp_wei[n]);
        chk($sformatf("u%0d e%0d win_last", u, n), 32'(o_last[u]), exp_last[n]);
        chk($sformatf("u%0d e%0d anchor_l", u, n), o_al[u], exp_al[n]);
        chk($sformatf("u%0d e%0d anchor_c", u, n), o_ac[u], exp_ac[n]);
        got_img.push_back(int'(o_img[u]));
        got_wei.push_back(int'(o_wei[u]));
        got_last.push_back(int'(o_last[u]));
        got_al.push_back(int'(o_al[u]));
        got_ac.push_back(int'(o_ac[u]));
        n++;
      end
    end
  endtask

  int e4 [4];
  int e8 [8];
  int e9 [9];

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) conv_on[i] = 1'b0;
    img_bus = '0;
    w_bus = '0;
    repeat (3) @(negedge clk);
    chk("reset img_cal", 32'(o_img[0]), 0);
    chk("reset wei_cal", 32'(o_wei[0]), 0);
    chk("reset cal_valid", 32'(o_valid[0]), 0);
    chk("reset win_last", 32'(o_last[0]), 0);
    chk("reset frame_done", 32'(o_done[0]), 0);
    chk("reset anchor_l", o_al[0], 0);
    chk("reset anchor_c", o_ac[0], 0);
    chk("reset busy", 32'(o_busy[0]), 0);
    rst = 1'b0;

    // Default configuration, img k+1, unit weights.
    for (int k = 0; k < 32; k++) img_m[k] = (k < 16) ? k + 1 : 0;
    for (int k = 0; k < 9; k++) wei_m[k] = 'h3C00;
    drive_buses();
    build(2, 2, 1, 0, 1);
    run_frame(0, 0, -1);
    e4 = '{1, 2, 5, 6};
    for (int i = 0; i < 4; i++) chk($sformatf("win0 img%0d", i), got_img[i], e4[i]);
    chk("win0 last on 3rd", got_last[2], 0);
    chk("win0 last on 4th", got_last[3], 1);
    e4 = '{11, 12, 15, 16};
    for (int i = 0; i < 4; i++) chk($sformatf("winlast img%0d", i), got_img[32 + i], e4[i]);
    chk("winlast anchor_l", got_al[35], 2);
    chk("winlast anchor_c", got_ac[35], 2);
    chk("default count", got_img.size(), 36);

    // 3x3 kernel with one-pixel zero border.
    build(3, 3, 1, 1, 1);
    run_frame(1, 0, -1);
    chk("pad count", got_img.size(), 144);
    e9 = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
    for (int i = 0; i < 9; i++) chk($sformatf("pad win00 img%0d", i), got_img[i], e9[i]);
    e9 = '{11, 12, 0, 15, 16, 0, 0, 0, 0};
    for (int i = 0; i < 9; i++) chk($sformatf("pad win33 img%0d", i), got_img[135 + i], e9[i]);
    chk("pad win33 anchor_l", got_al[143], 3);
    chk("pad win33 anchor_c", got_ac[143], 3);

    // Stride 2.
    build(2, 2, 1, 0, 2);
    run_frame(2, 0, -1);
    chk("stride count", got_img.size(), 16);
    e4 = '{3, 4, 7, 8};
    for (int i = 0; i < 4; i++) chk($sformatf("stride win01 img%0d", i), got_img[4 + i], e4[i]);
    chk("stride win01 anchor_c", got_ac[4], 1);
    e4 = '{11, 12, 15, 16};
    for (int i = 0; i < 4; i++) chk($sformatf("stride win11 img%0d", i), got_img[12 + i], e4[i]);

    // Two channels.
    for (int k = 0; k < 16; k++) img_m[16 + k] = k + 1 + 'h100;
    for (int k = 4; k < 8; k++) wei_m[k] = 'h4000;
    drive_buses();
    build(2, 2, 2, 0, 1);
    run_frame(3, 0, -1);
    chk("ch2 count", got_img.size(), 72);
    e8 = '{1, 2, 5, 6, 'h101, 'h102, 'h105, 'h106};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ch2 win0 img%0d", i), got_img[i], e8[i]);
      chk($sformatf("ch2 win0 wei%0d", i), got_wei[i], (i < 4) ? 'h3C00 : 'h4000);
      chk($sformatf("ch2 win0 last%0d", i), got_last[i], (i == 7) ? 1 : 0);
    end

    // Backpressure on element 5.
    build(2, 2, 1, 0, 1);
    run_frame(0, 2, -1);
    chk("stall count", got_img.size(), 36);

    // Reset mid-frame with element 10 on the bus, then restart with new data.
    run_frame(0, 0, 9);
    chk("pre-reset img", 32'(o_img[0]), exp_img[9]);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset img_cal", 32'(o_img[0]), 0);
    chk("midreset wei_cal", 32'(o_wei[0]), 0);
    chk("midreset cal_valid", 32'(o_valid[0]), 0);
    chk("midreset win_last", 32'(o_last[0]), 0);
    chk("midreset frame_done", 32'(o_done[0]), 0);
    chk("midreset anchor_l", o_al[0], 0);
    chk("midreset anchor_c", o_ac[0], 0);
    chk("midreset busy", 32'(o_busy[0]), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post-reset no done %0d", i), 32'(o_done[0]), 0);
    end
    for (int k = 0; k < 16; k++) img_m[k] = k + 'h21;
    drive_buses();
    build(2, 2, 1, 0, 1);
    run_frame(0, 0, -1);
    chk("restart first img", got_img[0], 'h21);
    chk("restart anchor_l", got_al[0], 0);
    chk("restart anchor_c", got_ac[0], 0);

    // Random data with random backpressure.
    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < 32; k++) img_m[k] = int'($urandom_range(0, 65535));
      for (int k = 0; k < 9; k++) wei_m[k] = int'($urandom_range(0, 65535));
      drive_buses();
      build(2, 2, 1, 0, 1);
      run_frame(0, 1, -1);
      build(3, 3, 1, 1, 1);
      run_frame(1, 1, -1);
      build(2, 2, 2, 0, 1);
      run_frame(3, 1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
